// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed NUM_DIGITS-digit hexadecimal seven-segment driver.
//   A load strobe captures a value, sign and decimal points.
//   Each digit is then driven in turn onto a shared active-low segment bus.
//   Leading zeros can be blanked, and a minus sign fills the first blanked
//   digit. A live blank input turns every digit off.
//
// Ports
//   clk    : system clock
//   rst    : synchronous reset, active high
//   load   : single-cycle strobe, captures value/neg/dp_in
//   value  : NUM_DIGITS hex nibbles, nibble 0 = least significant digit
//   neg    : show a minus sign left of the most significant shown digit
//   dp_in  : decimal point request per digit (1 = on)
//   blank  : 1 = all digits off (not latched)
//   HEX    : segments a..g, active low, registered
//   an     : digit enables, active low, one-hot-low, registered
//   dp     : decimal point, active low, registered
module seg7_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int LZ_SUPPRESS = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    neg,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank,
    output logic [0:6]              HEX,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    dp
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    // Segment patterns are held as [6:0] with bit 6 = segment a, so the
    // literals read in the same a..g order as the HEX[0:6] port.
    function automatic logic [6:0] seg_code(input logic [3:0] nib);
        case (nib)
            4'h0: seg_code = 7'b0000001;
            4'h1: seg_code = 7'b1001111;
            4'h2: seg_code = 7'b0010010;
            4'h3: seg_code = 7'b0000110;
            4'h4: seg_code = 7'b1001100;
            4'h5: seg_code = 7'b0100100;
            4'h6: seg_code = 7'b0100000;
            4'h7: seg_code = 7'b0001111;
            4'h8: seg_code = 7'b0000000;
            4'h9: seg_code = 7'b0001100;
            4'hA: seg_code = 7'b0001000;
            4'hB: seg_code = 7'b1100000;
            4'hC: seg_code = 7'b0110001;
            4'hD: seg_code = 7'b1000010;
            4'hE: seg_code = 7'b0110000;
            default: seg_code = 7'b0111000;
        endcase
    endfunction

    logic [PW-1:0]           presc_q, presc_d;
    logic [IW-1:0]           idx_q, idx_d;
    // Load is staged one cycle before it reaches the shadow.
    // A load that coincides with a digit change therefore shows the new digit
    // with the old data for one cycle.
    logic                    ld_q, ld_d;
    logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
    logic                    pend_neg_q, pend_neg_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [4*NUM_DIGITS-1:0] shd_val_q, shd_val_d;
    logic                    shd_neg_q, shd_neg_d;
    logic [NUM_DIGITS-1:0]   shd_dp_q, shd_dp_d;
    logic [6:0]              hex_q, hex_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    dp_q, dp_d;

    logic                    tc;
    logic [NUM_DIGITS-1:0]   supp;
    logic [NUM_DIGITS-1:0]   minus_pos;
    logic                    all_zero;
    logic [3:0]              cur_nib;
    logic                    cur_supp;
    logic                    cur_minus;
    logic                    cur_dp;

    always_comb begin
        tc      = (presc_q == PRESC_LAST);
        presc_d = tc ? '0 : presc_q + 1'b1;
        idx_d   = idx_q;
        if (tc) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        ld_d       = load;
        pend_val_d = load ? value : pend_val_q;
        pend_neg_d = load ? neg   : pend_neg_q;
        pend_dp_d  = load ? dp_in : pend_dp_q;
        shd_val_d  = ld_q ? pend_val_q : shd_val_q;
        shd_neg_d  = ld_q ? pend_neg_q : shd_neg_q;
        shd_dp_d   = ld_q ? pend_dp_q  : shd_dp_q;
    end

    // Digit i (i > 0) is suppressed when it and every digit above it are zero.
    // The minus sign goes into the lowest suppressed digit.
    always_comb begin
        supp      = '0;
        minus_pos = '0;
        all_zero  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            all_zero = all_zero && (shd_val_q[4*i +: 4] == 4'h0);
            supp[i]  = (LZ_SUPPRESS != 0) && all_zero;
        end
        for (int i = 1; i < NUM_DIGITS; i++) begin
            minus_pos[i] = shd_neg_q && supp[i] && ((i == 1) || !supp[i-1]);
        end
    end

    always_comb begin
        cur_nib   = 4'h0;
        cur_supp  = 1'b0;
        cur_minus = 1'b0;
        cur_dp    = 1'b0;
        an_d      = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_nib   = shd_val_q[4*i +: 4];
                cur_supp  = supp[i];
                cur_minus = minus_pos[i];
                cur_dp    = shd_dp_q[i];
                an_d[i]   = 1'b0;
            end
        end

        if (cur_minus) begin
            hex_d = 7'b1111110;
        end else if (cur_supp) begin
            hex_d = 7'b1111111;
        end else begin
            hex_d = seg_code(cur_nib);
        end
        dp_d = ~cur_dp;

        if (blank) begin
            hex_d = 7'b1111111;
            an_d  = '1;
            dp_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q    <= '0;
            idx_q      <= '0;
            ld_q       <= 1'b0;
            pend_val_q <= '0;
            pend_neg_q <= 1'b0;
            pend_dp_q  <= '0;
            shd_val_q  <= '0;
            shd_neg_q  <= 1'b0;
            shd_dp_q   <= '0;
            hex_q      <= 7'b1111111;
            an_q       <= '1;
            dp_q       <= 1'b1;
        end else begin
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            ld_q       <= ld_d;
            pend_val_q <= pend_val_d;
            pend_neg_q <= pend_neg_d;
            pend_dp_q  <= pend_dp_d;
            shd_val_q  <= shd_val_d;
            shd_neg_q  <= shd_neg_d;
            shd_dp_q   <= shd_dp_d;
            hex_q      <= hex_d;
            an_q       <= an_d;
            dp_q       <= dp_d;
        end
    end

    assign HEX = hex_q;
    assign an  = an_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [31:0] value;
    logic        neg;
    logic [7:0]  dp_in;
    logic        blank;

    logic [0:6]  hex_a, hex_b, hex_c;
    logic [3:0]  an_a, an_b;
    logic [2:0]  an_c;
    logic        dp_a, dp_b, dp_c;

    always #5 clk = ~clk;

    // A: 4 digits, 4-cycle slots, zero suppression on
    seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .LZ_SUPPRESS(1)) u_a (
        .clk(clk), .rst(rst), .load(load), .value(value[15:0]), .neg(neg),
        .dp_in(dp_in[3:0]), .blank(blank), .HEX(hex_a), .an(an_a), .dp(dp_a));
    // B: 4 digits, index advances every cycle
    seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(1), .LZ_SUPPRESS(1)) u_b (
        .clk(clk), .rst(rst), .load(load), .value(value[15:0]), .neg(neg),
        .dp_in(dp_in[3:0]), .blank(blank), .HEX(hex_b), .an(an_b), .dp(dp_b));
    // C: 3 digits, 3-cycle slots, zero suppression off
    seg7_scan_driver #(.NUM_DIGITS(3), .REFRESH_DIV(3), .LZ_SUPPRESS(0)) u_c (
        .clk(clk), .rst(rst), .load(load), .value(value[11:0]), .neg(neg),
        .dp_in(dp_in[2:0]), .blank(blank), .HEX(hex_c), .an(an_c), .dp(dp_c));

    typedef struct {
        int          at;
        logic [31:0] v;
        logic        ng;
        logic [7:0]  d;
    } ld_t;

    ld_t hist[$];
    int  n_edges;
    int  checks;
    int  failures;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] tbl [16];
        tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        return tbl[d];
    endfunction

    // Expected {hex[6:0], an[7:0], dp} after edge n of the run since reset.
    // Output at edge n shows slot floor((n-1)/rd) with the data of the most
    // recent load taken at edge n-2 or earlier.
    function automatic logic [15:0] model(input int n, input bit off, input int nd,
                                          input int rd, input bit lz);
        logic [31:0] sv;
        logic        sn;
        logic [7:0]  sd;
        logic [6:0]  h;
        logic [7:0]  a;
        int          idx;
        int          top;
        if (off || n == 0) return {7'h7F, 8'hFF, 1'b1};
        sv = '0; sn = 1'b0; sd = '0;
        foreach (hist[k]) begin
            if (hist[k].at <= n - 2) begin
                sv = hist[k].v; sn = hist[k].ng; sd = hist[k].d;
            end
        end
        idx = ((n - 1) / rd) % nd;
        top = 0;
        for (int i = 0; i < nd; i++) begin
            if (((sv >> (4 * i)) & 32'hF) != 0) top = i;
        end
        if (!lz) top = nd - 1;
        if (idx <= top)                 h = seg_of(4'((sv >> (4 * idx)) & 32'hF));
        else if (sn && idx == top + 1)  h = 7'b1111110;
        else                            h = 7'b1111111;
        a = ~(8'h01 << idx);
        return {h, a, ~sd[idx]};
    endfunction

    task automatic step(input bit r, input bit l, input logic [31:0] v, input bit ng,
                        input logic [7:0] d, input bit b);
        logic [15:0] e;
        rst = r; load = l; value = v; neg = ng; dp_in = d; blank = b;
        @(posedge clk);
        if (r) begin
            n_edges = 0;
            hist.delete();
        end else begin
            n_edges++;
            if (l) hist.push_back('{n_edges, v, ng, d});
        end
        @(negedge clk);
        e = model(n_edges, r || b, 4, 4, 1'b1);
        check("A_hex", 32'(hex_a), 32'(e[15:9]));
        check("A_an",  {28'hFFFFFFF, an_a}, {24'hFFFFFF, e[8:1]});
        check("A_dp",  32'(dp_a), 32'(e[0]));
        e = model(n_edges, r || b, 4, 1, 1'b1);
        check("B_hex", 32'(hex_b), 32'(e[15:9]));
        check("B_an",  {28'hFFFFFFF, an_b}, {24'hFFFFFF, e[8:1]});
        check("B_dp",  32'(dp_b), 32'(e[0]));
        e = model(n_edges, r || b, 3, 3, 1'b0);
        check("C_hex", 32'(hex_c), 32'(e[15:9]));
        check("C_an",  {29'h1FFFFFFF, an_c}, {24'hFFFFFF, e[8:1]});
        check("C_dp",  32'(dp_c), 32'(e[0]));
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 1'b0, value, neg, dp_in, 1'b0);
    endtask

    task automatic do_load(input logic [31:0] v, input bit ng, input logic [7:0] d);
        step(1'b0, 1'b1, v, ng, d, 1'b0);
    endtask

    initial begin
        checks = 0; failures = 0; n_edges = 0;
        rst = 1'b1; load = 1'b0; value = '0; neg = 1'b0; dp_in = '0; blank = 1'b0;

        // reset held two cycles, then release and watch digit 0 come up
        step(1'b1, 1'b0, 32'h0, 1'b0, 8'h0, 1'b0);
        step(1'b1, 1'b1, 32'h1234, 1'b1, 8'hFF, 1'b0);
        idle(6);

        // scan/decode
        do_load(32'h12AF, 1'b0, 8'h00);
        idle(34);

        // suppression and minus, then all-zero value
        do_load(32'h0005, 1'b1, 8'h00);
        idle(18);
        do_load(32'h0000, 1'b0, 8'h00);
        idle(18);

        // MSB nonzero leaves no room for the minus
        do_load(32'h8000, 1'b1, 8'h00);
        idle(18);
        do_load(32'h0005, 1'b0, 8'h00);
        idle(18);

        // blank pulse mid-scan with one decimal point
        do_load(32'h4321, 1'b0, 8'h04);
        idle(9);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, value, neg, dp_in, 1'b1);
        idle(20);

        // load on a terminal count of instance A
        for (int i = 0; i < 4 && ((n_edges + 1) % 4) != 0; i++) idle(1);
        do_load(32'h9E70, 1'b1, 8'h02);
        idle(8);

        // reset while instance A shows digit 2
        for (int i = 0; i < 16 && !(((n_edges / 4) % 4) == 2 && (n_edges % 4) == 1); i++) idle(1);
        step(1'b1, 1'b0, value, neg, dp_in, 1'b0);
        idle(10);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            logic [31:0] v;
            v = $urandom >> (4 * $urandom_range(0, 8));
            step($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0, v,
                 1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 15) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised, time-multiplexed N-digit hexadecimal seven-segment display driver for the calculator result path.
- Latches an N-nibble value on a load strobe and scans one digit at a time onto a shared active-low segment bus with per-digit active-low enables.
- Adds what the plain nibble decoder lacks: refresh timing, leading-zero suppression, minus-sign insertion, decimal points and global blanking.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (1..8).
- REFRESH_DIV, 50000, clock cycles each digit stays active (>=1).
- LZ_SUPPRESS, 1, 1 = blank leading zero digits; 0 = always show all digits.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- load  in  1  single-cycle strobe; captures value/neg/dp_in into the shadow registers.
- value  in  4*NUM_DIGITS  hex digits; nibble i = value[4i+3:4i], digit 0 = least significant.
- neg  in  1  show minus sign left of the most significant displayed digit.
- dp_in  in  NUM_DIGITS  decimal point request per digit (1 = on).
- blank  in  1  1 = all digits off (live, not latched).
- HEX  out  [0:6]  segments a..g, active low, registered.
- an  out  NUM_DIGITS  digit enables, active low, one-hot-low, registered.
- dp  out  1  decimal point, active low, registered.

Behaviour:
- Reset (synchronous, on rst=1 at a clk edge): prescaler=0, digit index=0, shadow value=0, shadow neg=0, shadow dp=0; HEX=1111111, an=all ones, dp=1.
- Shadow capture: load=1 at edge t -> shadow holds the new data from t+1. load is ignored while rst=1.
- Prescaler: counts 0..REFRESH_DIV-1, then wraps to 0.
  - On the terminal count, the digit index advances; it wraps NUM_DIGITS-1 -> 0.
  - With REFRESH_DIV=1, the index advances every cycle.
- Output stage: registered each cycle from the current index and shadow. Outputs therefore lag the index by 1 cycle, and lag load by 2 cycles.
  - an: bit [idx]=0, all other bits 1.
  - If blank=1, an=all ones, HEX=1111111, dp=1. The prescaler and index keep running.
- Hex segment codes (HEX[0:6]):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0001100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Leading-zero suppression (LZ_SUPPRESS=1):
  - Digit i>0 is suppressed when nibbles i..NUM_DIGITS-1 are all zero. Digit 0 is never suppressed (value 0 shows "0").
  - A suppressed digit drives HEX=1111111. Its an bit still goes low in its slot, so scan timing is uniform.
- Minus sign:
  - If shadow neg=1 and at least one digit is suppressed, the lowest-index suppressed digit shows 1111110 (segment g only).
  - If no digit is suppressed (MSB nonzero, or LZ_SUPPRESS=0), the minus is not shown.
- Decimal point: dp = ~shadow_dp[idx], independent of suppression; forced 1 when blank=1.
- Simultaneous events:
  - load and terminal count in the same cycle: the new index displays the old shadow for 1 cycle, then the new data.
  - rst has priority over load and the terminal count.
  - rst mid-scan restarts at digit 0 with outputs off for the first cycle after reset.

Test Plan:
- Reset: NUM_DIGITS=4, REFRESH_DIV=4, hold rst 2 cycles -> HEX=1111111, an=1111, dp=1. First cycle after rst release: outputs still off. Next cycle: an=1110, HEX=0000001.
- Scan/decode: load value=16'h12AF -> over 16 cycles, an cycles 1110,1101,1011,0111, each held 4 cycles, with HEX=0111000, 0001000, 0010010, 1001111; the pattern repeats.
- Suppression plus minus: load value=16'h0005, neg=1 -> digit0=0100100, digit1=1111110, digits 2,3=1111111. Load value=16'h0000, neg=0 -> digit0=0000001, others blank.
- No room for minus / LZ off: value=16'h8000, neg=1 -> no digit shows 1111110. Rebuild with LZ_SUPPRESS=0, value=16'h0005 -> digits 1..3 show 0000001.
- Blank/dp: dp_in=4'b0100, blank pulsed for 3 cycles mid-scan -> an=1111, HEX=1111111, dp=1 during blank; scan phase unchanged afterwards; dp=0 only while an=1011.
- Boundaries: REFRESH_DIV=1 -> index advances every cycle. load coincident with terminal count -> old data shown for 1 cycle, then new. rst asserted mid-digit-2 -> restart at digit 0.
